// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 keyboard receiver.
package ps2_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        PARITY,
        STOP
    } ps2_state_e;

    localparam logic [7:0]  PS2_BREAK_CODE = 8'hF0;
    localparam logic [7:0]  PS2_EXT_CODE   = 8'hE0;
    localparam int unsigned PS2_DATA_BITS  = 8;

    // Odd parity: data bits plus parity bit must hold an odd number of ones.
    function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
        return ^{data, par};
    endfunction

endpackage

// File: rtl/ps2_receiver_if.sv
// Output bundle of the PS/2 receiver: code strobe, prefix flags, error strobes, busy.
interface ps2_receiver_if;

    logic [7:0] o_data;
    logic       o_valid;
    logic       o_break;
    logic       o_ext;
    logic       o_parity_err;
    logic       o_frame_err;
    logic       o_busy;

    modport master (
        output o_data, o_valid, o_break, o_ext, o_parity_err, o_frame_err, o_busy
    );

    modport slave (
        input o_data, o_valid, o_break, o_ext, o_parity_err, o_frame_err, o_busy
    );

endinterface

// File: rtl/ps2_line_filter.sv
// 2-FF synchroniser followed by a FILTER_LEN-deep all-equal hold filter.
// Resets to the idle-high level so no edge appears after reset release.
module ps2_line_filter #(
    parameter int unsigned FILTER_LEN = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic raw_i,
    output logic level_o,
    output logic fall_o
);

    logic [1:0]            sync_q;
    logic [FILTER_LEN-1:0] hist_q;
    logic                  level_q;
    logic                  fall_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q  <= '1;
            hist_q  <= '1;
            level_q <= 1'b1;
            fall_q  <= 1'b0;
        end else begin
            sync_q <= {sync_q[0], raw_i};
            hist_q <= {hist_q[FILTER_LEN-2:0], sync_q[1]};
            fall_q <= 1'b0;
            // Level only moves when every sample agrees; mixed history holds it.
            if (hist_q == '0 && level_q) begin
                level_q <= 1'b0;
                fall_q  <= 1'b1;
            end else if (hist_q == '1) begin
                level_q <= 1'b1;
            end
        end
    end

    assign level_o = level_q;
    assign fall_o  = fall_q;

endmodule

// File: rtl/ps2_receiver.sv
// PS/2 host-bound frame receiver: filtered clock, 11-bit deserialiser, parity/framing
// checks and timeout recovery. PS2_RECEIVER_BREAK_DECODE_EN folds E0/F0 prefixes into flags.
module ps2_receiver
    import ps2_pkg::*;
#(
    parameter int unsigned FILTER_LEN     = 8,
    parameter int unsigned TIMEOUT_CYCLES = 100000
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           i_ps2c,
    input  logic           i_ps2d,
    ps2_receiver_if.master bus
);

    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TMAX      = TW'(TIMEOUT_CYCLES);
    localparam logic [TW-1:0] TMAX_M1   = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [2:0]    LAST_BIT  = 3'(PS2_DATA_BITS - 1);

    logic       c_fall;
    logic [1:0] d_sync_q;
    logic       d_s;

    ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filter (
        .clk    (clk),
        .rst    (rst),
        .raw_i  (i_ps2c),
        .level_o(),
        .fall_o (c_fall)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) d_sync_q <= '1;
        else     d_sync_q <= {d_sync_q[0], i_ps2d};
    end
    assign d_s = d_sync_q[1];

    ps2_state_e state_q;
    logic [2:0]    bitcnt_q;
    logic [7:0]    shift_q;
    logic          par_q;
    logic [TW-1:0] tcnt_q;
    logic [7:0]    data_q;
    logic          valid_q, perr_q, ferr_q, busy_q;
    logic          timeout_d;
`ifdef PS2_RECEIVER_BREAK_DECODE_EN
    logic          brk_q, ext_q, brk_flag_q, ext_flag_q;
`endif

    // A sample edge in the same cycle as expiry wins: the frame is still alive.
    always_comb begin
        timeout_d = (state_q != IDLE) && !c_fall && (tcnt_q == TMAX_M1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            bitcnt_q <= '0;
            shift_q  <= '0;
            par_q    <= 1'b0;
            tcnt_q   <= '0;
            data_q   <= '0;
            valid_q  <= 1'b0;
            perr_q   <= 1'b0;
            ferr_q   <= 1'b0;
            busy_q   <= 1'b0;
`ifdef PS2_RECEIVER_BREAK_DECODE_EN
            brk_q      <= 1'b0;
            ext_q      <= 1'b0;
            brk_flag_q <= 1'b0;
            ext_flag_q <= 1'b0;
`endif
        end else begin
            valid_q <= 1'b0;
            perr_q  <= 1'b0;
            ferr_q  <= 1'b0;
`ifdef PS2_RECEIVER_BREAK_DECODE_EN
            brk_q <= 1'b0;
            ext_q <= 1'b0;
`endif
            if (state_q == IDLE || c_fall)  tcnt_q <= '0;
            else if (tcnt_q != TMAX)        tcnt_q <= tcnt_q + 1'b1;

            if (timeout_d) begin
                state_q <= IDLE;
                busy_q  <= 1'b0;
                ferr_q  <= 1'b1;
`ifdef PS2_RECEIVER_BREAK_DECODE_EN
                brk_flag_q <= 1'b0;
                ext_flag_q <= 1'b0;
`endif
            end else if (c_fall) begin
                case (state_q)
                    IDLE: begin
                        if (!d_s) begin
                            state_q  <= DATA;
                            bitcnt_q <= '0;
                            busy_q   <= 1'b1;
                        end
                    end
                    DATA: begin
                        shift_q  <= {d_s, shift_q[7:1]};
                        bitcnt_q <= bitcnt_q + 1'b1;
                        if (bitcnt_q == LAST_BIT) state_q <= PARITY;
                    end
                    PARITY: begin
                        par_q   <= d_s;
                        state_q <= STOP;
                    end
                    STOP: begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                        if (!d_s || !odd_parity_ok(shift_q, par_q)) begin
                            ferr_q <= !d_s;
                            perr_q <= d_s;
`ifdef PS2_RECEIVER_BREAK_DECODE_EN
                            brk_flag_q <= 1'b0;
                            ext_flag_q <= 1'b0;
`endif
                        end else begin
`ifdef PS2_RECEIVER_BREAK_DECODE_EN
                            if (shift_q == PS2_EXT_CODE) begin
                                ext_flag_q <= 1'b1;
                            end else if (shift_q == PS2_BREAK_CODE) begin
                                brk_flag_q <= 1'b1;
                            end else begin
                                data_q     <= shift_q;
                                valid_q    <= 1'b1;
                                brk_q      <= brk_flag_q;
                                ext_q      <= ext_flag_q;
                                brk_flag_q <= 1'b0;
                                ext_flag_q <= 1'b0;
                            end
`else
                            data_q  <= shift_q;
                            valid_q <= 1'b1;
`endif
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign bus.o_data       = data_q;
    assign bus.o_valid      = valid_q;
    assign bus.o_parity_err = perr_q;
    assign bus.o_frame_err  = ferr_q;
    assign bus.o_busy       = busy_q;
`ifdef PS2_RECEIVER_BREAK_DECODE_EN
    assign bus.o_break = brk_q;
    assign bus.o_ext   = ext_q;
`else
    assign bus.o_break = 1'b0;
    assign bus.o_ext   = 1'b0;
`endif

endmodule

// File: tb/tb_ps2_receiver.sv
// Scoreboard bench for ps2_receiver: PS/2 frames in, strobes checked by an independent monitor.
module tb_ps2_receiver;

    localparam int unsigned FL = 8;
    localparam int unsigned TO = 300;
    localparam int unsigned H  = 25;   // half PS/2 clock period in clk cycles

    localparam int K_VALID = 0;
    localparam int K_PERR  = 1;
    localparam int K_FERR  = 2;

    typedef struct {
        int          kind;
        logic [7:0]  data;
        logic        brk;
        logic        ext;
        int unsigned cyc;
    } exp_t;

    logic clk  = 1'b0;
    logic rst  = 1'b1;
    logic ps2c = 1'b1;
    logic ps2d = 1'b1;

    ps2_receiver_if bus_if ();

    ps2_receiver #(.FILTER_LEN(FL), .TIMEOUT_CYCLES(TO)) dut (
        .clk   (clk),
        .rst   (rst),
        .i_ps2c(ps2c),
        .i_ps2d(ps2d),
        .bus   (bus_if)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int          checks = 0;
    int          errors = 0;
    exp_t        sb[$];
    logic [7:0]  m_last = 8'h00;
    logic        m_brk  = 1'b0;
    logic        m_ext  = 1'b0;
    int unsigned fall_cyc;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: outcome of one complete frame from the protocol rules.
    task automatic model_frame(input logic [7:0] d, input logic p, input logic s,
                               input int unsigned at);
        exp_t e;
        e.cyc = at; e.brk = 1'b0; e.ext = 1'b0; e.data = m_last;
        if (!s) begin
            e.kind = K_FERR; m_brk = 1'b0; m_ext = 1'b0; sb.push_back(e);
        end else if ((($countones(d) + int'(p)) % 2) == 0) begin
            e.kind = K_PERR; m_brk = 1'b0; m_ext = 1'b0; sb.push_back(e);
        end else begin
`ifdef PS2_RECEIVER_BREAK_DECODE_EN
            if (d == 8'hE0) m_ext = 1'b1;
            else if (d == 8'hF0) m_brk = 1'b1;
            else begin
                e.kind = K_VALID; e.data = d; e.brk = m_brk; e.ext = m_ext;
                m_last = d; m_brk = 1'b0; m_ext = 1'b0; sb.push_back(e);
            end
`else
            e.kind = K_VALID; e.data = d; m_last = d; sb.push_back(e);
`endif
        end
    endtask

    task automatic bit_lead(input logic b);
        @(negedge clk);
        ps2d = b;
        repeat (H) @(negedge clk);
        ps2c = 1'b0;
        fall_cyc = cyc;
    endtask

    task automatic bit_trail();
        repeat (H) @(negedge clk);
        ps2c = 1'b1;
    endtask

    task automatic send_bit(input logic b);
        bit_lead(b);
        bit_trail();
    endtask

    task automatic send_frame(input logic [7:0] d, input logic pflip, input logic stopb);
        logic p;
        p = ~(^d) ^ pflip;
        chk("busy_idle", {31'b0, bus_if.o_busy}, 32'd0);
        send_bit(1'b0);
        chk("busy_in_frame", {31'b0, bus_if.o_busy}, 32'd1);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
        send_bit(p);
        bit_lead(stopb);
        model_frame(d, p, stopb, fall_cyc + FL + 4);
        bit_trail();
    endtask

    task automatic glitch(input string name, input int unsigned n, input logic d);
        logic seen;
        seen = 1'b0;
        @(negedge clk);
        ps2d = d;
        ps2c = 1'b0;
        repeat (n) @(negedge clk);
        ps2c = 1'b1;
        repeat (FL + 10) begin
            @(negedge clk);
            if (bus_if.o_busy) seen = 1'b1;
        end
        ps2d = 1'b1;
        chk(name, {31'b0, seen}, 32'd0);
    endtask

    // Monitor: any strobe pops the oldest expectation and is compared against it.
    int   mon_kind;
    int   mon_n;
    exp_t mon_e;
    always @(negedge clk) begin
        if (!rst && (bus_if.o_valid || bus_if.o_parity_err || bus_if.o_frame_err)) begin
            mon_n    = int'(bus_if.o_valid) + int'(bus_if.o_parity_err) + int'(bus_if.o_frame_err);
            mon_kind = bus_if.o_valid ? K_VALID : (bus_if.o_parity_err ? K_PERR : K_FERR);
            chk("single_strobe", mon_n, 32'd1);
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_strobe: got kind %0d at cycle %0d, required none",
                         mon_kind, cyc);
            end else begin
                mon_e = sb.pop_front();
                chk("strobe_kind",  mon_kind, mon_e.kind);
                chk("strobe_cycle", cyc, mon_e.cyc);
                chk("o_data",       {24'b0, bus_if.o_data}, {24'b0, mon_e.data});
                chk("o_break",      {31'b0, bus_if.o_break}, {31'b0, mon_e.brk});
                chk("o_ext",        {31'b0, bus_if.o_ext}, {31'b0, mon_e.ext});
                chk("busy_at_strobe", {31'b0, bus_if.o_busy}, 32'd0);
            end
        end
    end

    initial begin
        logic [7:0]  rd;
        int unsigned w;

        repeat (4) @(negedge clk);
        chk("rst_o_data",  {24'b0, bus_if.o_data}, 32'd0);
        chk("rst_o_valid", {31'b0, bus_if.o_valid}, 32'd0);
        chk("rst_o_busy",  {31'b0, bus_if.o_busy}, 32'd0);
        chk("rst_o_ferr",  {31'b0, bus_if.o_frame_err}, 32'd0);
        rst = 1'b0;
        repeat (10) @(negedge clk);

        send_frame(8'h1C, 1'b0, 1'b1);
        send_frame(8'h1C, 1'b1, 1'b1);

        glitch("glitch_3_no_busy", 3, 1'b0);
        glitch("glitch_len_minus1_no_busy", FL - 1, 1'b0);
        glitch("noise_edge_data1_no_busy", FL, 1'b1);

        // Aborted frame: start + 4 data bits, then idle until timeout.
        send_bit(1'b0);
        for (int i = 0; i < 3; i++) send_bit(1'($urandom_range(0, 1)));
        bit_lead(1'($urandom_range(0, 1)));
        begin
            exp_t e;
            e.kind = K_FERR; e.data = m_last; e.brk = 1'b0; e.ext = 1'b0;
            e.cyc  = fall_cyc + FL + 4 + TO;
            m_brk = 1'b0; m_ext = 1'b0;
            sb.push_back(e);
        end
        bit_trail();
        ps2d = 1'b1;
        repeat (TO + FL + 20) @(negedge clk);
        send_frame(8'h29, 1'b0, 1'b1);

        send_frame(8'hE0, 1'b0, 1'b1);
        send_frame(8'hF0, 1'b0, 1'b1);
        send_frame(8'h75, 1'b0, 1'b1);

        send_frame(8'h5A, 1'b0, 1'b0);

        for (int n = 0; n < 20; n++) begin
            rd = 8'($urandom);
            send_frame(rd, ($urandom_range(0, 3) == 0), ($urandom_range(0, 7) != 0));
            repeat ($urandom_range(0, 40)) @(negedge clk);
        end

        // Reset in the middle of a frame.
        send_bit(1'b0);
        for (int i = 0; i < 5; i++) send_bit(1'($urandom_range(0, 1)));
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("midrst_o_data",  {24'b0, bus_if.o_data}, 32'd0);
        chk("midrst_o_valid", {31'b0, bus_if.o_valid}, 32'd0);
        chk("midrst_o_perr",  {31'b0, bus_if.o_parity_err}, 32'd0);
        chk("midrst_o_ferr",  {31'b0, bus_if.o_frame_err}, 32'd0);
        chk("midrst_o_busy",  {31'b0, bus_if.o_busy}, 32'd0);
        chk("midrst_o_break", {31'b0, bus_if.o_break}, 32'd0);
        chk("midrst_o_ext",   {31'b0, bus_if.o_ext}, 32'd0);
        chk("midrst_sb_empty", sb.size(), 32'd0);
        ps2c = 1'b1;
        ps2d = 1'b1;
        m_last = 8'h00; m_brk = 1'b0; m_ext = 1'b0;
        repeat (5) @(negedge clk);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        send_frame(8'h1C, 1'b0, 1'b1);

        w = 0;
        while (sb.size() != 0 && w < 2000) begin
            @(negedge clk);
            w++;
        end
        repeat (20) @(negedge clk);
        chk("scoreboard_drained", sb.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
